// File: rtl/sme_match_scheduler_pkg.sv
// Shared definitions for the KMP match-engine scheduler.
//
// Holds the scheduler state encoding and the default sizing values used by
// sme_match_scheduler and sme_free_picker.
package sme_match_scheduler_pkg;

  // Default sizing: engines, window width, string and pattern index widths.
  localparam int NUM_ENG_DEF   = 4;
  localparam int WIN_DEF       = 8;
  localparam int STR_ADD_W_DEF = 6;
  localparam int PAT_ADD_W_DEF = 3;

  // Scheduler states, 3-bit encoding.
  typedef enum logic [2:0] {
    SCH_IDLE     = 3'd0,
    SCH_SETUP    = 3'd1,
    SCH_DISPATCH = 3'd2,
    SCH_DRAIN    = 3'd3,
    SCH_REPORT   = 3'd4
  } sch_state_t;

endpackage

// File: rtl/sme_match_scheduler_free_picker.sv
// sme_free_picker: lowest-index free engine selector.
//
// Ports:
//   busy_mask  in   N  one bit per engine, 1 = engine busy
//   grant      out  N  one-hot, lowest-index engine whose busy bit is 0
//   valid      out  1  at least one engine is free
module sme_free_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0] busy_mask,
  output logic [N-1:0] grant,
  output logic         valid
);

  logic [N-1:0] free;

  // Isolating the lowest set bit of the free vector: x & (~x + 1).
  assign free  = ~busy_mask;
  assign grant = free & (~free + N'(1));
  assign valid = |free;

endmodule

// File: rtl/sme_match_scheduler.sv
// sme_match_scheduler: dispatches fixed-size windows of candidate start
// positions to parallel KMP match engines and reports the earliest match.
//
// Optional feature macro: SME_EARLY_STOP_EN
//   When defined, windows whose base lies beyond an already-found match are
//   not dispatched; the reported position is the same either way.
//
// Ports:
//   clk           in   1               rising-edge clock
//   reset         in   1               asynchronous, active-low reset
//   mem_valid     in   1               string/pattern/failure function ready
//   str_last_idx  in   STR_ADD_W       index of last string byte
//   pat_last_idx  in   PAT_ADD_W       index of last pattern byte
//   eng_start     out  NUM_ENG         one-cycle start pulse per engine
//   eng_base      out  NUM_ENG*STR_ADD_W  first candidate start per engine
//   eng_end       out  NUM_ENG*STR_ADD_W  last candidate start per engine
//   eng_done      in   NUM_ENG         one-cycle completion pulse per engine
//   eng_hit       in   NUM_ENG         engine found a match (with eng_done)
//   eng_pos       in   NUM_ENG*STR_ADD_W  lowest match start per engine
//   busy          out  1               high whenever not IDLE
//   o_valid       out  1               one-cycle result pulse
//   o_match       out  1               at least one match recorded
//   o_pos         out  STR_ADD_W       earliest match start, 0 if none
module sme_match_scheduler
  import sme_match_scheduler_pkg::*;
#(
  parameter int NUM_ENG   = NUM_ENG_DEF,
  parameter int WIN       = WIN_DEF,
  parameter int STR_ADD_W = STR_ADD_W_DEF,
  parameter int PAT_ADD_W = PAT_ADD_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mem_valid,
  input  logic [STR_ADD_W-1:0]         str_last_idx,
  input  logic [PAT_ADD_W-1:0]         pat_last_idx,
  output logic [NUM_ENG-1:0]           eng_start,
  output logic [NUM_ENG*STR_ADD_W-1:0] eng_base,
  output logic [NUM_ENG*STR_ADD_W-1:0] eng_end,
  input  logic [NUM_ENG-1:0]           eng_done,
  input  logic [NUM_ENG-1:0]           eng_hit,
  input  logic [NUM_ENG*STR_ADD_W-1:0] eng_pos,
  output logic                         busy,
  output logic                         o_valid,
  output logic                         o_match,
  output logic [STR_ADD_W-1:0]         o_pos
);

  localparam int WIN_LG = $clog2(WIN);
  // Window counter must be able to hold nwin itself (up to 2^STR_ADD_W/WIN).
  localparam int KW     = STR_ADD_W - WIN_LG + 1;

  sch_state_t state, next_state;

  logic [STR_ADD_W-1:0] str_last_q;
  logic [PAT_ADD_W-1:0] pat_last_q;
  logic [STR_ADD_W-1:0] last_start_q;
  logic [KW-1:0]        nwin_q;
  logic [KW-1:0]        win_cnt;
  logic [STR_ADD_W-1:0] best_q;
  logic                 found_q;
  logic [NUM_ENG-1:0]   busy_mask;
  logic [STR_ADD_W-1:0] base_q [NUM_ENG];
  logic [STR_ADD_W-1:0] end_q  [NUM_ENG];

  logic [STR_ADD_W:0]   last_start_full;
  logic                 no_cand;
  logic [STR_ADD_W-1:0] win_base;
  logic [STR_ADD_W-1:0] win_end_raw;
  logic [STR_ADD_W-1:0] win_end;
  logic                 windows_left;
  logic                 last_window;
  logic                 stop_early;
  logic [NUM_ENG-1:0]   grant;
  logic                 pick_valid;
  logic                 dispatch_fire;
  logic [NUM_ENG-1:0]   done_acc;
  logic                 hit_any;
  logic [STR_ADD_W-1:0] best_d;

  sme_free_picker #(.N(NUM_ENG)) u_picker (
    .busy_mask (busy_mask),
    .grant     (grant),
    .valid     (pick_valid)
  );

  // One extra bit so a pattern longer than the string shows up as a borrow.
  assign last_start_full = {1'b0, str_last_q} - (STR_ADD_W+1)'(pat_last_q);
  assign no_cand         = last_start_full[STR_ADD_W];

  // Current window bounds; the last window is clipped to last_start.
  assign win_base     = STR_ADD_W'(win_cnt) << WIN_LG;
  assign win_end_raw  = win_base | STR_ADD_W'(WIN - 1);
  assign win_end      = (win_end_raw > last_start_q) ? last_start_q : win_end_raw;
  assign windows_left = (win_cnt < nwin_q);
  assign last_window  = (win_cnt == nwin_q - KW'(1));

  // A window starting beyond the best match so far cannot improve it.
  always_comb begin
`ifdef SME_EARLY_STOP_EN
    stop_early = found_q && (win_base > best_q);
`else
    stop_early = 1'b0;
`endif
  end

  // Only the registered busy mask feeds the picker, so an engine finishing
  // this cycle is not eligible again until the next one.
  assign dispatch_fire = (state == SCH_DISPATCH) && windows_left &&
                         !stop_early && pick_valid;

  // Completion merge: done pulses from idle engines are dropped; every
  // accepted hit competes for the new best position.
  always_comb begin
    done_acc = eng_done & busy_mask;
    hit_any  = 1'b0;
    best_d   = best_q;
    for (int i = 0; i < NUM_ENG; i++) begin
      if (done_acc[i] && eng_hit[i]) begin
        hit_any = 1'b1;
        if (eng_pos[i*STR_ADD_W +: STR_ADD_W] < best_d) begin
          best_d = eng_pos[i*STR_ADD_W +: STR_ADD_W];
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SCH_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      SCH_IDLE: begin
        if (mem_valid) next_state = SCH_SETUP;
      end
      SCH_SETUP: begin
        next_state = no_cand ? SCH_REPORT : SCH_DISPATCH;
      end
      SCH_DISPATCH: begin
        if (stop_early || !windows_left) begin
          next_state = SCH_DRAIN;
        end else if (dispatch_fire && last_window) begin
          next_state = SCH_DRAIN;
        end
      end
      SCH_DRAIN: begin
        if (busy_mask == '0) next_state = SCH_REPORT;
      end
      SCH_REPORT: begin
        next_state = SCH_IDLE;
      end
      default: next_state = SCH_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    eng_start = dispatch_fire ? grant : '0;
    busy      = (state != SCH_IDLE);
    o_valid   = (state == SCH_REPORT);
    o_match   = found_q;
    o_pos     = found_q ? best_q : '0;
  end

  // Job bookkeeping: latched sizes, window counter, best/found and the
  // per-engine busy mask and held window bounds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      str_last_q   <= '0;
      pat_last_q   <= '0;
      last_start_q <= '0;
      nwin_q       <= '0;
      win_cnt      <= '0;
      best_q       <= '0;
      found_q      <= 1'b0;
      busy_mask    <= '0;
      for (int i = 0; i < NUM_ENG; i++) begin
        base_q[i] <= '0;
        end_q[i]  <= '0;
      end
    end else begin
      if ((state == SCH_IDLE) && mem_valid) begin
        str_last_q <= str_last_idx;
        pat_last_q <= pat_last_idx;
      end
      if (state == SCH_SETUP) begin
        last_start_q <= last_start_full[STR_ADD_W-1:0];
        nwin_q       <= KW'(last_start_full[STR_ADD_W-1:0] >> WIN_LG) + KW'(1);
        win_cnt      <= '0;
        best_q       <= '1;
        found_q      <= 1'b0;
      end else begin
        best_q  <= best_d;
        found_q <= found_q | hit_any;
        if (dispatch_fire) win_cnt <= win_cnt + KW'(1);
      end
      busy_mask <= (busy_mask & ~done_acc) | (dispatch_fire ? grant : '0);
      for (int i = 0; i < NUM_ENG; i++) begin
        if (dispatch_fire && grant[i]) begin
          base_q[i] <= win_base;
          end_q[i]  <= win_end;
        end
      end
    end
  end

  // During the start pulse the new bounds are forwarded; afterwards the
  // registered copy holds them for as long as the engine is busy.
  for (genvar g = 0; g < NUM_ENG; g++) begin : g_bounds
    assign eng_base[g*STR_ADD_W +: STR_ADD_W] = eng_start[g] ? win_base : base_q[g];
    assign eng_end[g*STR_ADD_W +: STR_ADD_W]  = eng_start[g] ? win_end  : end_q[g];
  end

endmodule

// File: tb/tb_sme_match_scheduler.sv
// Self-checking bench for sme_match_scheduler with behavioural engine models.
// Optional feature macro honoured: SME_EARLY_STOP_EN.
module tb_sme_match_scheduler;

  localparam int NE = 4;
  localparam int W  = 8;
  localparam int SW = 6;
  localparam int PW = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             mem_valid;
  logic [SW-1:0]    str_last_idx;
  logic [PW-1:0]    pat_last_idx;
  logic [NE-1:0]    eng_start;
  logic [NE*SW-1:0] eng_base;
  logic [NE*SW-1:0] eng_end;
  logic [NE-1:0]    eng_done;
  logic [NE-1:0]    eng_hit;
  logic [NE*SW-1:0] eng_pos;
  logic             busy;
  logic             o_valid;
  logic             o_match;
  logic [SW-1:0]    o_pos;

  sme_match_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .mem_valid    (mem_valid),
    .str_last_idx (str_last_idx),
    .pat_last_idx (pat_last_idx),
    .eng_start    (eng_start),
    .eng_base     (eng_base),
    .eng_end      (eng_end),
    .eng_done     (eng_done),
    .eng_hit      (eng_hit),
    .eng_pos      (eng_pos),
    .busy         (busy),
    .o_valid      (o_valid),
    .o_match      (o_match),
    .o_pos        (o_pos)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Engine models and the "text": hit_map[p] = pattern matches at start p.
  bit        m_busy    [NE];
  bit        m_release [NE];
  int        m_cnt     [NE];
  int        m_lo      [NE];
  int        m_hi      [NE];
  bit [63:0] hit_map;
  int        lat_tab   [8];
  bit        use_lat_tab;

  // Per-job observations.
  int job_last;
  int cyc;
  int starts_seen;
  int first_start_cyc;
  int valid_cyc;
  int valid_count;
  bit seen_match;
  int seen_pos;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic clearEngines();
    for (int i = 0; i < NE; i++) begin
      m_busy[i] = 0; m_release[i] = 0; m_cnt[i] = 0; m_lo[i] = 0; m_hi[i] = 0;
    end
    eng_done = '0; eng_hit = '0; eng_pos = '0;
  endtask

  // Advance one clock, then observe starts/results and drive engine replies.
  task automatic tick();
    int lo, hi, pf;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NE; i++) begin
      if (m_release[i]) begin m_busy[i] = 0; m_release[i] = 0; end
    end
    eng_done = '0; eng_hit = '0; eng_pos = '0;
    for (int i = 0; i < NE; i++) begin
      if (eng_start[i]) begin
        checkOutput("start_to_free_engine", 64'(m_busy[i]), 64'd0);
        lo = starts_seen * W;
        hi = (lo + W - 1 < job_last) ? lo + W - 1 : job_last;
        checkOutput("window_base", 64'(eng_base[i*SW +: SW]), 64'(lo));
        checkOutput("window_end",  64'(eng_end[i*SW +: SW]),  64'(hi));
        if (first_start_cyc < 0) first_start_cyc = cyc;
        m_busy[i] = 1; m_lo[i] = lo; m_hi[i] = hi;
        m_cnt[i]  = use_lat_tab ? lat_tab[starts_seen % 8] : int'($urandom_range(1, 10));
        starts_seen++;
      end else if (m_busy[i]) begin
        m_cnt[i]--;
        if (m_cnt[i] == 0) begin
          checkOutput("base_held", 64'(eng_base[i*SW +: SW]), 64'(m_lo[i]));
          pf = -1;
          for (int p = m_lo[i]; p <= m_hi[i]; p++) if (hit_map[p] && pf < 0) pf = p;
          eng_done[i] = 1'b1;
          eng_hit[i]  = (pf >= 0);
          eng_pos[i*SW +: SW] = (pf >= 0) ? SW'(pf) : SW'(0);
          m_release[i] = 1;
        end
      end
    end
    if (o_valid) begin
      valid_count++;
      if (valid_cyc < 0) begin
        valid_cyc = cyc; seen_match = o_match; seen_pos = int'(o_pos);
      end
    end
  endtask

  // Run one job from mem_valid to report and check it against the model.
  task automatic applyStimulus(input int s, input int p, input bit inject_mv);
    int exp_pos, nwin;
    job_last = s - p;
    cyc = 0; starts_seen = 0; first_start_cyc = -1; valid_cyc = -1; valid_count = 0;
    seen_match = 0; seen_pos = 0;
    exp_pos = -1;
    for (int q = 0; q <= job_last; q++) if (hit_map[q] && exp_pos < 0) exp_pos = q;
    nwin = (job_last < 0) ? 0 : job_last / W + 1;
    str_last_idx = SW'(s); pat_last_idx = PW'(p); mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    checkOutput("busy_after_mem_valid", 64'(busy), 64'd1);
    for (int n = 0; n < 300 && valid_cyc < 0; n++) begin
      if (inject_mv && cyc == 3 && job_last >= 0) begin
        str_last_idx = '0; pat_last_idx = PW'(7); mem_valid = 1'b1;
      end else begin
        mem_valid = 1'b0;
      end
      tick();
    end
    mem_valid = 1'b0;
    checkOutput("report_within_budget", 64'(valid_cyc >= 0), 64'd1);
    for (int n = 0; n < 3; n++) tick();
    checkOutput("valid_pulse_count", 64'(valid_count), 64'd1);
    checkOutput("result_match", 64'(seen_match), 64'(exp_pos >= 0));
    checkOutput("result_pos", 64'(seen_pos), 64'((exp_pos >= 0) ? exp_pos : 0));
    checkOutput("held_match", 64'(o_match), 64'(exp_pos >= 0));
    checkOutput("held_pos", 64'(o_pos), 64'((exp_pos >= 0) ? exp_pos : 0));
    checkOutput("idle_after_report", 64'(busy), 64'd0);
    if (job_last < 0) begin
      checkOutput("nocand_report_latency", 64'(valid_cyc), 64'd2);
      checkOutput("nocand_starts", 64'(starts_seen), 64'd0);
    end else begin
      checkOutput("first_start_latency", 64'(first_start_cyc), 64'd2);
`ifdef SME_EARLY_STOP_EN
      checkOutput("start_count_bound", 64'(starts_seen <= nwin), 64'd1);
`else
      checkOutput("start_count", 64'(starts_seen), 64'(nwin));
`endif
    end
  endtask

  initial begin
    reset = 1'b0; mem_valid = 1'b0; str_last_idx = '0; pat_last_idx = '0;
    hit_map = '0; use_lat_tab = 1'b0; job_last = 0; cyc = 0; starts_seen = 0;
    for (int k = 0; k < 8; k++) lat_tab[k] = 5;
    clearEngines();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_valid", 64'(o_valid), 64'd0);
    checkOutput("reset_match", 64'(o_match), 64'd0);
    checkOutput("reset_pos", 64'(o_pos), 64'd0);
    checkOutput("reset_start", 64'(eng_start), 64'd0);
    checkOutput("reset_base", 64'(eng_base), 64'd0);
    reset = 1'b1;
    tick();

    // 1: no hits, fixed latency 5.
    $display("[TB] step 1: no-hit job");
    use_lat_tab = 1'b1; hit_map = '0;
    applyStimulus(31, 3, 1'b0);
    checkOutput("t1_windows", 64'(starts_seen), 64'd4);

    // 2: hits at 17 and 25, window 3 finishes one cycle before window 2.
    $display("[TB] step 2: two hits, out-of-order completion");
    hit_map = '0; hit_map[17] = 1'b1; hit_map[25] = 1'b1;
    lat_tab[2] = 6; lat_tab[3] = 4;
    applyStimulus(31, 3, 1'b0);

    // 3: pattern longer than string.
    $display("[TB] step 3: no candidates");
    applyStimulus(3, 7, 1'b0);

    // 4: full string, random latencies, plus randomized jobs.
    $display("[TB] step 4: random latencies");
    use_lat_tab = 1'b0; hit_map = '0;
    applyStimulus(63, 0, 1'b1);
    for (int j = 0; j < 8; j++) begin
      hit_map = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      applyStimulus(int'($urandom_range(0, 63)), int'($urandom_range(0, 7)), 1'b1);
    end

    // 5: early hit in window 0.
    $display("[TB] step 5: early hit");
    use_lat_tab = 1'b1; hit_map = '0; hit_map[3] = 1'b1; hit_map[45] = 1'b1;
    for (int k = 0; k < 8; k++) lat_tab[k] = 8;
    lat_tab[0] = 4;
    applyStimulus(63, 0, 1'b0);
`ifdef SME_EARLY_STOP_EN
    checkOutput("t5_starts_early", 64'(starts_seen), 64'd4);
`else
    checkOutput("t5_starts_all", 64'(starts_seen), 64'd8);
`endif

    // 6: reset during dispatch with two engines busy.
    $display("[TB] step 6: reset mid-job");
    hit_map = '0;
    for (int k = 0; k < 8; k++) lat_tab[k] = 20;
    job_last = 63; cyc = 0; starts_seen = 0; first_start_cyc = -1;
    str_last_idx = SW'(63); pat_last_idx = '0; mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    tick();
    tick();
    checkOutput("t6_two_started", 64'(starts_seen), 64'd2);
    #2 reset = 1'b0;
    #1;
    checkOutput("t6_busy_async", 64'(busy), 64'd0);
    checkOutput("t6_start_async", 64'(eng_start), 64'd0);
    clearEngines();
    @(posedge clk);
    #1;
    checkOutput("t6_busy", 64'(busy), 64'd0);
    checkOutput("t6_valid", 64'(o_valid), 64'd0);
    checkOutput("t6_match", 64'(o_match), 64'd0);
    checkOutput("t6_pos", 64'(o_pos), 64'd0);
    checkOutput("t6_base", 64'(eng_base), 64'd0);
    checkOutput("t6_end", 64'(eng_end), 64'd0);
    reset = 1'b1;
    eng_done = 4'b0011; eng_hit = 4'b0011;
    eng_pos = '0; eng_pos[SW-1:0] = SW'(5); eng_pos[2*SW-1:SW] = SW'(9);
    tick();
    checkOutput("t6_stale_busy", 64'(busy), 64'd0);
    checkOutput("t6_stale_match", 64'(o_match), 64'd0);
    checkOutput("t6_stale_pos", 64'(o_pos), 64'd0);
    tick();
    checkOutput("t6_stale_valid", 64'(o_valid), 64'd0);
    checkOutput("t6_stale_start", 64'(eng_start), 64'd0);
    hit_map[12] = 1'b1;
    for (int k = 0; k < 8; k++) lat_tab[k] = 3;
    applyStimulus(40, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
